// File: rtl/dbg_pkg.sv
// Shared types and default sizing for the debug command engine.
// Holds the engine FSM state encoding used by dbg_cmd_engine.
package dbg_pkg;

    localparam int unsigned DBG_ADDR_WIDTH = 2;
    localparam int unsigned DBG_DATA_WIDTH = 32;
    localparam int unsigned DBG_CMD_DEPTH  = 4;
    localparam int unsigned DBG_TIMEOUT    = 255;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        CAPTURE,
        RESPOND
    } state_t;

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Generic power-of-two FIFO with full/empty flags, head visible combinationally.
// Push is dropped when full and pop is ignored when empty; no same-cycle bypass.
module dbg_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/dbg_cmd_engine.sv
// Queues host debug commands and runs them one at a time on a req/ack register port.
// Response held until rsp_ready; cmd_ready drops when the command FIFO is full.
module dbg_cmd_engine
    import dbg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DBG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DBG_DATA_WIDTH,
    parameter int unsigned CMD_DEPTH  = DBG_CMD_DEPTH,
    parameter int unsigned TIMEOUT    = DBG_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_term,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  term,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  wr_en,
    output logic                  req,
    input  logic                  ack
);

    typedef struct packed {
        logic                  term;
        logic                  rnw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    cmd_t                  fifo_in, head_cmd;
    logic                  fifo_full, fifo_empty, pop;
    state_t                state_q;
    logic                  cur_rnw_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q, addr_q;
    logic [DATA_WIDTH-1:0] cur_data_q, wdata_q, rsp_data_q;
    logic [TW-1:0]         tmo_q;
    logic                  term_q, req_q, wr_en_q, rsp_valid_q, rsp_err_q;

    assign fifo_in = '{term: cmd_term, rnw: cmd_rnw, addr: cmd_addr, data: cmd_data};

    dbg_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (cmd_valid),
        .push_dat_i (fifo_in),
        .full_o     (fifo_full),
        .pop_i      (pop),
        .head_dat_o (head_cmd),
        .empty_o    (fifo_empty)
    );

    // Holding off while term is high keeps back-to-back terms as separate pulses.
    assign pop = (state_q == IDLE) && !fifo_empty && !term_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_rnw_q   <= 1'b0;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            req_q       <= 1'b0;
            tmo_q       <= '0;
            term_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            term_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        if (head_cmd.term) begin
                            term_q <= 1'b1;
                        end else begin
                            cur_rnw_q  <= head_cmd.rnw;
                            cur_addr_q <= head_cmd.addr;
                            cur_data_q <= head_cmd.data;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // A target still holding ack would see req rise into it.
                    if (!ack) begin
                        addr_q  <= cur_addr_q;
                        wdata_q <= cur_data_q;
                        wr_en_q <= !cur_rnw_q;
                        req_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack) begin
                        req_q   <= 1'b0;
                        wr_en_q <= 1'b0;
                        if (cur_rnw_q) begin
                            state_q <= CAPTURE;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b0;
                            state_q     <= RESPOND;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        req_q       <= 1'b0;
                        wr_en_q     <= 1'b0;
                        tmo_q       <= tmo_q + 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESPOND;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= read_data;
                    rsp_err_q   <= 1'b0;
                    state_q     <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = !fifo_full;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign term       = term_q;
    assign addr       = addr_q;
    assign write_data = wdata_q;
    assign wr_en      = wr_en_q;
    assign req        = req_q;

endmodule

// File: tb/tb_dbg_cmd_engine.sv
// Randomised scoreboard bench for dbg_cmd_engine with a register-file target model.
module tb_dbg_cmd_engine;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int NEVER = -1;
    localparam int HANG  = -2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_rnw, cmd_term;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_data;
    logic          term;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data, read_data;
    logic          wr_en, req, ack;

    always #5 clk = ~clk;

    dbg_cmd_engine #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CMD_DEPTH  (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rnw    (cmd_rnw),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_term   (cmd_term),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .term       (term),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .wr_en      (wr_en),
        .req        (req),
        .ack        (ack)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    typedef struct {
        int            delay;
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } tgt_t;

    rsp_t          exp_q[$];
    tgt_t          tgt_q[$];
    int            term_q[$];
    logic [DW-1:0] model_regs [4];
    logic [DW-1:0] tgt_regs [4];
    int            nonterm_acc = 0;
    int            rsp_seen    = 0;
    bit            rsp_hold    = 1'b0;
    int            checks      = 0;
    int            fails       = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outcome is fixed at acceptance: commands run in order against a register file.
    task automatic push_cmd(input bit is_term, input bit rnw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int delay);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_term  = is_term;
        cmd_rnw   = rnw;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            check("push_accept_timeout", 1, 0);
            cmd_valid = 1'b0;
            return;
        end
        if (is_term) begin
            term_q.push_back(nonterm_acc);
        end else begin
            nonterm_acc++;
            tgt_q.push_back('{delay: delay, rnw: rnw, addr: a, data: d});
            if (delay == NEVER) begin
                exp_q.push_back('{data: '0, err: 1'b1});
            end else if (delay != HANG) begin
                if (rnw) begin
                    exp_q.push_back('{data: model_regs[a], err: 1'b0});
                end else begin
                    exp_q.push_back('{data: '0, err: 1'b0});
                    model_regs[a] = d;
                end
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || term_q.size() != 0 || tgt_q.size() != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) check("drain_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    // Response and term monitor; also owns rsp_ready.
    logic          prev_vld = 1'b0, prev_acc = 1'b0, prev_term = 1'b0, prev_err = 1'b0;
    logic [DW-1:0] prev_data = '0;
    initial begin
        rsp_t e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = rsp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rst) begin
                prev_vld  = 1'b0;
                prev_term = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                if (prev_vld && !prev_acc) begin
                    check("rsp_stable_data", rsp_data, prev_data);
                    check("rsp_stable_err", rsp_err, prev_err);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", rsp_err, e.err);
                    end
                    rsp_seen++;
                end
            end
            prev_vld  = rsp_valid;
            prev_acc  = rsp_valid && rsp_ready;
            prev_data = rsp_data;
            prev_err  = rsp_err;
            if (term) begin
                check("term_width", prev_term, 0);
                if (term_q.size() == 0) check("term_unexpected", 1, 0);
                else check("term_order", rsp_seen, term_q.pop_front());
            end
            prev_term = term;
        end
    end

    // Debug-port target: register file acking after a per-command delay.
    initial begin
        tgt_t t;
        int   n;
        ack       = 1'b0;
        read_data = '0;
        forever begin
            @(negedge clk);
            if (rst || !req) continue;
            if (tgt_q.size() == 0) begin
                check("req_unexpected", 1, 0);
                n = 0;
                while (req && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                continue;
            end
            t = tgt_q.pop_front();
            check("port_addr", addr, t.addr);
            check("port_wr_en", wr_en, !t.rnw);
            if (!t.rnw) check("port_wdata", write_data, t.data);
            if (t.delay == HANG) begin
                n = 0;
                while (req && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                continue;
            end
            if (t.delay == NEVER) begin
                n = 0;
                while (req && n < 1000) begin
                    n++;
                    @(negedge clk);
                end
                check("timeout_req_cycles", n, TMO);
                check("timeout_wr_en_low", wr_en, 0);
                continue;
            end
            for (int i = 0; i < t.delay; i++) begin
                @(negedge clk);
                check("req_held", req, 1);
                check("wr_en_held", wr_en, !t.rnw);
            end
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            check("req_drop", req, 0);
            check("wr_en_drop", wr_en, 0);
            if (!t.rnw) begin
                tgt_regs[t.addr] = t.data;
            end else begin
                read_data = tgt_regs[t.addr];
                @(negedge clk);
                read_data = $urandom;
            end
        end
    end

    bit            r_term, r_rnw;
    int            r_dly, busy;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_term  = 1'b0;
        cmd_rnw   = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        for (int i = 0; i < 4; i++) begin
            model_regs[i] = '0;
            tgt_regs[i]   = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_term", term, 0);
        check("reset_addr", addr, 0);
        check("reset_write_data", write_data, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_req", req, 0);
        rst = 1'b0;

        push_cmd(1'b0, 1'b0, 2'd0, 32'hDEADBEEF, 3);
        push_cmd(1'b0, 1'b0, 2'd2, 32'h12345678, 0);
        push_cmd(1'b0, 1'b1, 2'd2, 32'h0, 1);
        drain();
        push_cmd(1'b0, 1'b1, 2'd1, 32'h0, NEVER);
        drain();

        // Engine parked in RESPOND so the FIFO fills with exactly CMD_DEPTH entries.
        rsp_hold = 1'b1;
        push_cmd(1'b0, 1'b0, 2'd3, 32'hA5A5_0003, 0);
        busy = 0;
        while (!rsp_valid && busy < 100) begin
            @(negedge clk);
            busy++;
        end
        check("full_first_rsp_seen", rsp_valid, 1);
        for (int i = 0; i < DEPTH; i++)
            push_cmd(1'b0, 1'(i % 2), AW'(i), $urandom, i);
        @(negedge clk);
        check("cmd_ready_full", cmd_ready, 0);
        fork
            push_cmd(1'b0, 1'b1, 2'd3, 32'h0, 2);
            begin
                repeat (5) @(negedge clk);
                check("cmd_ready_still_full", cmd_ready, 0);
                rsp_hold = 1'b0;
            end
        join
        drain();

        push_cmd(1'b0, 1'b0, 2'd1, 32'hCAFE_F00D, 2);
        push_cmd(1'b1, 1'b0, 2'd0, 32'h0, 0);
        drain();
        push_cmd(1'b1, 1'b0, 2'd0, 32'h0, 0);
        push_cmd(1'b1, 1'b0, 2'd0, 32'h0, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            r_term = ($urandom_range(0, 7) == 0);
            r_rnw  = 1'($urandom_range(0, 1));
            r_addr = AW'($urandom_range(0, 3));
            r_data = $urandom;
            r_dly  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
            push_cmd(r_term, r_rnw, r_addr, r_data, r_dly);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();

        // Reset mid-WAIT_ACK with two reads queued behind the stalled one.
        push_cmd(1'b0, 1'b1, 2'd0, 32'h0, HANG);
        push_cmd(1'b0, 1'b1, 2'd1, 32'h0, 0);
        push_cmd(1'b0, 1'b1, 2'd2, 32'h0, 0);
        busy = 0;
        while (!req && busy < 100) begin
            @(negedge clk);
            busy++;
        end
        @(negedge clk);
        check("pre_reset_req", req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_req", req, 0);
        check("mid_reset_wr_en", wr_en, 0);
        check("mid_reset_rsp_valid", rsp_valid, 0);
        check("mid_reset_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        tgt_q.delete();
        term_q.delete();
        nonterm_acc = 0;
        rsp_seen    = 0;
        @(negedge clk);
        rst  = 1'b0;
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (req || rsp_valid) busy++;
        end
        check("post_reset_quiet_cycles", busy, 0);

        push_cmd(1'b0, 1'b0, 2'd3, 32'h0BAD_BEEF, 1);
        push_cmd(1'b0, 1'b1, 2'd3, 32'h0, 0);
        drain();
        check("end_exp_q_empty", exp_q.size(), 0);
        check("end_tgt_q_empty", tgt_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
